// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
// Default operand width, iteration count, counter sizing and FSM state encoding.
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_ITER  = MUL_WIDTH;

  // Wide enough to hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int MUL_CNT_W = cnt_width(MUL_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negation: dout = neg ? -din : din.
// Used for operand magnitudes and for the final product sign fix.
module cond_negate #(
  parameter int N = 32
) (
  input  logic         neg,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);

  assign dout = neg ? (~din + N'(1)) : din;

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier, signed (MULT) or unsigned (MULTU), fixed latency.
// Produces the full 2*WIDTH product into hi_out/lo_out with a start/busy/done handshake.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start_sig; operands latched on accept
//   CALC  | WIDTH add/shift iterations on the operand magnitudes
//   FIX   | sign correction, load hi/lo, pulse done_sig
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk_sig,
  input  logic             rst_n_sig,
  input  logic             ena_sig,
  input  logic             start_sig,
  input  logic             sign_flag,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy_sig,
  output logic             done_sig,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int ITER  = WIDTH;
  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH:0]   acc_added;

  assign neg_a = ~sign_flag & op_a[WIDTH-1];
  assign neg_b = ~sign_flag & op_b[WIDTH-1];

  cond_negate #(.N(WIDTH)) u_abs_a (
    .neg  (neg_a),
    .din  (op_a),
    .dout (abs_a)
  );

  cond_negate #(.N(WIDTH)) u_abs_b (
    .neg  (neg_b),
    .din  (op_b),
    .dout (abs_b)
  );

  cond_negate #(.N(2*WIDTH)) u_fix (
    .neg  (neg_q),
    .din  (acc_q[2*WIDTH-1:0]),
    .dout (product)
  );

  // Bit 2W of acc is always clear entering an iteration, so the upper sum never overflows W+1 bits.
  assign upper_sum = acc_q[2*WIDTH:WIDTH] + {1'b0, mag_a_q};
  assign acc_added = mag_b_q[0] ? {upper_sum, acc_q[WIDTH-1:0]} : acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      IDLE: begin
        if (start_sig) begin
          mag_a_d = abs_a;
          mag_b_d = abs_b;
          neg_d   = neg_a ^ neg_b;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = acc_added >> 1;
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        hi_d    = product[2*WIDTH-1:WIDTH];
        lo_d    = product[WIDTH-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ena_sig low freezes everything, including a pending done pulse.
  always_ff @(posedge clk_sig or negedge rst_n_sig) begin
    if (!rst_n_sig) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (ena_sig) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_sig = busy_q;
  assign done_sig = done_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed-vector bench for seq_multiplier: products, latency, stall, abort, back-to-back.
module tb_seq_multiplier;

  localparam int W = 32;

  logic         clk_sig = 1'b0;
  logic         rst_n_sig = 1'b0;
  logic         ena_sig = 1'b1;
  logic         start_sig = 1'b0;
  logic         sign_flag = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy_sig;
  logic         done_sig;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;

  int n_cmp = 0;
  int n_bad = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk_sig   (clk_sig),
    .rst_n_sig (rst_n_sig),
    .ena_sig   (ena_sig),
    .start_sig (start_sig),
    .sign_flag (sign_flag),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy_sig  (busy_sig),
    .done_sig  (done_sig),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  always #5 clk_sig = ~clk_sig;

  // Issues one request on edge E0 and returns the edge index at which done was first seen (-1 on timeout).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sf,
                        output logic [W-1:0] hi, output logic [W-1:0] lo, output int edges,
                        output logic busy_e0);
    @(negedge clk_sig);
    op_a = a; op_b = b; sign_flag = sf; start_sig = 1'b1;
    @(posedge clk_sig); #1;
    start_sig = 1'b0;
    busy_e0 = busy_sig;
    edges = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk_sig); #1;
      if (done_sig) begin
        edges = k;
        break;
      end
    end
    hi = hi_out;
    lo = lo_out;
  endtask

  task automatic test_reset();
    n_cmp++; if (busy_sig !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy_sig); end
    n_cmp++; if (done_sig !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", done_sig); end
    n_cmp++; if (hi_out !== '0) begin n_bad++; $display("FAIL reset_hi got %h want 0", hi_out); end
    n_cmp++; if (lo_out !== '0) begin n_bad++; $display("FAIL reset_lo got %h want 0", lo_out); end
  endtask

  task automatic test_products();
    logic [W-1:0] hi, lo;
    int           e;
    logic         b0;

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, hi, lo, e, b0);
    n_cmp++; if (b0 !== 1'b1) begin n_bad++; $display("FAIL busy_after_e0 got %0b want 1", b0); end
    n_cmp++; if (e != 33) begin n_bad++; $display("FAIL latency_umax got %0d want 33", e); end
    n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL umax_hi got %h want fffffffe", hi); end
    n_cmp++; if (lo !== 32'h0000_0001) begin n_bad++; $display("FAIL umax_lo got %h want 00000001", lo); end
    n_cmp++; if (busy_sig !== 1'b0) begin n_bad++; $display("FAIL busy_in_done got %0b want 0", busy_sig); end
    @(posedge clk_sig); #1;
    n_cmp++; if (done_sig !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width got %0b want 0", done_sig); end

    run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, hi, lo, e, b0);
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sneg1x2_hi got %h want ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL sneg1x2_lo got %h want fffffffe", lo); end

    run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, hi, lo, e, b0);
    n_cmp++; if (hi !== 32'h0000_0001) begin n_bad++; $display("FAIL umaxx2_hi got %h want 00000001", hi); end
    n_cmp++; if (lo !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL umaxx2_lo got %h want fffffffe", lo); end

    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, hi, lo, e, b0);
    n_cmp++; if (hi !== 32'h4000_0000) begin n_bad++; $display("FAIL sminxmin_hi got %h want 40000000", hi); end
    n_cmp++; if (lo !== 32'h0000_0000) begin n_bad++; $display("FAIL sminxmin_lo got %h want 00000000", lo); end

    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, hi, lo, e, b0);
    n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sminx1_hi got %h want ffffffff", hi); end
    n_cmp++; if (lo !== 32'h8000_0000) begin n_bad++; $display("FAIL sminx1_lo got %h want 80000000", lo); end
  endtask

  // 7x6 with an ignored 3x3 at E10, then 3x3 issued in the done cycle: done expected at E33 and E67.
  task automatic test_back_to_back();
    int first = -1;
    int second = -1;
    @(negedge clk_sig);
    op_a = 32'd7; op_b = 32'd6; sign_flag = 1'b1; start_sig = 1'b1;
    @(posedge clk_sig); #1;
    start_sig = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      if (k == 10) begin
        op_a = 32'd3; op_b = 32'd3; start_sig = 1'b1;
      end
      @(posedge clk_sig); #1;
      start_sig = 1'b0;
      if (k == 10) begin
        op_a = 32'd7; op_b = 32'd6;
      end
      if (done_sig && first < 0) begin
        first = k;
        n_cmp++; if (hi_out !== 32'd0) begin n_bad++; $display("FAIL b2b_first_hi got %h want 0", hi_out); end
        n_cmp++; if (lo_out !== 32'd42) begin n_bad++; $display("FAIL b2b_first_lo got %0d want 42", lo_out); end
        op_a = 32'd3; op_b = 32'd3; start_sig = 1'b1;
        @(posedge clk_sig); #1;
        start_sig = 1'b0;
        k++;
        n_cmp++; if (busy_sig !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_busy got %0b want 1", busy_sig); end
      end else if (done_sig && first >= 0) begin
        second = k;
        break;
      end
      if (k == 50) begin
        n_cmp++; if (lo_out !== 32'd42) begin n_bad++; $display("FAIL b2b_hold_lo got %0d want 42", lo_out); end
      end
    end
    n_cmp++; if (first != 33) begin n_bad++; $display("FAIL b2b_first_edge got %0d want 33", first); end
    n_cmp++; if (second != 67) begin n_bad++; $display("FAIL b2b_second_edge got %0d want 67", second); end
    n_cmp++; if (lo_out !== 32'd9) begin n_bad++; $display("FAIL b2b_second_lo got %0d want 9", lo_out); end
  endtask

  // ena low for 5 cycles in CALC, then ena low again while done is pending.
  task automatic test_ena_stall();
    int e = -1;
    @(negedge clk_sig);
    op_a = 32'd5; op_b = 32'd7; sign_flag = 1'b1; start_sig = 1'b1;
    @(posedge clk_sig); #1;
    start_sig = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      if (k == 10) ena_sig = 1'b0;
      if (k == 15) ena_sig = 1'b1;
      @(posedge clk_sig); #1;
      if (done_sig) begin
        e = k;
        break;
      end
    end
    n_cmp++; if (e != 38) begin n_bad++; $display("FAIL stall_latency got %0d want 38", e); end
    n_cmp++; if (lo_out !== 32'd35) begin n_bad++; $display("FAIL stall_lo got %0d want 35", lo_out); end
    ena_sig = 1'b0;
    repeat (2) @(posedge clk_sig);
    #1;
    n_cmp++; if (done_sig !== 1'b1) begin n_bad++; $display("FAIL stall_done_held got %0b want 1", done_sig); end
    ena_sig = 1'b1;
    @(posedge clk_sig); #1;
    n_cmp++; if (done_sig !== 1'b0) begin n_bad++; $display("FAIL stall_done_release got %0b want 0", done_sig); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    @(negedge clk_sig);
    op_a = 32'd11; op_b = 32'd13; sign_flag = 1'b1; start_sig = 1'b1;
    @(posedge clk_sig); #1;
    start_sig = 1'b0;
    repeat (19) @(posedge clk_sig);
    #1;
    rst_n_sig = 1'b0;
    #1;
    n_cmp++; if (busy_sig !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %0b want 0", busy_sig); end
    n_cmp++; if (hi_out !== '0) begin n_bad++; $display("FAIL abort_hi got %h want 0", hi_out); end
    n_cmp++; if (lo_out !== '0) begin n_bad++; $display("FAIL abort_lo got %h want 0", lo_out); end
    @(negedge clk_sig);
    rst_n_sig = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk_sig); #1;
      if (done_sig) dones++;
    end
    n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL abort_no_done got %0d want 0", dones); end
  endtask

  task automatic test_zero();
    logic [W-1:0] hi, lo;
    int           e;
    logic         b0;
    int           dones = 1;
    run_op(32'd0, 32'h1234_5678, 1'b0, hi, lo, e, b0);
    n_cmp++; if (e != 33) begin n_bad++; $display("FAIL zero_latency got %0d want 33", e); end
    n_cmp++; if (hi !== '0) begin n_bad++; $display("FAIL zero_hi got %h want 0", hi); end
    n_cmp++; if (lo !== '0) begin n_bad++; $display("FAIL zero_lo got %h want 0", lo); end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_sig); #1;
      if (done_sig) dones++;
    end
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL zero_done_count got %0d want 1", dones); end
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk_sig);
    rst_n_sig = 1'b1;
    test_products();
    test_back_to_back();
    test_ena_stall();
    test_reset_mid();
    test_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
